bram_uart_sender: RTL
=====================

# bram_uart_sender

Transmit-side sequencer for the host serial link: on a one-cycle `send_over_uart` request from the UART/BRAM command controller, it reads one 32-bit word from block RAM, serialises the bytes selected by a 4-bit byte mask into the UART TX FIFO, and answers with a one-cycle `uart_send_complete`. It is the consumer of the controller's `send_over_uart` / `bytes_to_read` / `bram_read_addr` outputs and the producer of its `uart_send_complete` input.

## Interface
- `ASCII_HEX`, 0: 0 = raw bytes; 1 = each byte sent as two uppercase ASCII hex characters.
- `APPEND_NEWLINE`, 0: 1 = send 0x0A after the last selected byte.
- `clk` input 1: single clock, all logic on rising edge.
- `rst` input 1: reset is asynchronous and active-low (asserted at 0).
- `send_over_uart` input 1: start request, one-cycle pulse.
- `bytes_to_read` input 4: byte mask; bit i selects word bits [8i+7:8i].
- `bram_read_addr` input 9: word address to read.
- `bram_rd_en` output 1: BRAM read enable.
- `bram_rd_addr` output 9: BRAM read address.
- `bram_rd_data` input 32: BRAM data, valid the cycle after `bram_rd_en`.
- `uart_tx_data` output 8: byte to TX FIFO.
- `uart_tx_write` output 1: write strobe; byte accepted when high and `uart_tx_full`=0.
- `uart_tx_full` input 1: TX FIFO full.
- `uart_send_complete` output 1: one-cycle completion pulse.
- `busy` output 1: high in every state except IDLE.

## Operation
- States: IDLE, FETCH, CAPTURE, SEND, NEWLINE, DONE.
- IDLE: on `send_over_uart`, latch mask and address. Mask ≠ 0 → FETCH; mask = 0 → DONE (no BRAM read, no TX bytes, unless `APPEND_NEWLINE`=1 → NEWLINE).
- FETCH: `bram_rd_en`=1, `bram_rd_addr`=latched address, → CAPTURE.
- CAPTURE: register `bram_rd_data` into word register, → SEND.
- SEND: highest-numbered remaining mask bit selects the byte (byte 3 first, byte 0 last); unselected bytes skipped with zero cycles. Each cycle with `uart_tx_full`=0 writes one character and advances; with full=1 hold `uart_tx_write`=0 and all state. Hex mode: high nibble char, then low nibble char ('0'-'9' = 0x30-0x39, 'A'-'F' = 0x41-0x46). After last character → NEWLINE if `APPEND_NEWLINE` else DONE.
- NEWLINE: write 0x0A when not full, → DONE.
- DONE: `uart_send_complete`=1 for exactly one cycle, → IDLE.
- `send_over_uart` while `busy`=1 is ignored, not queued. Mask/address inputs are sampled only on accept.
- Reset: all outputs 0, state IDLE, word/mask registers 0. Reset mid-transfer aborts; no `uart_send_complete`.

## Timing
- Request sampled at edge T (state IDLE). FETCH during T+1, CAPTURE during T+2, first `uart_tx_write` during T+3 if not full.
- Raw mode, no back-pressure: N selected bytes occupy T+3..T+2+N; completion pulse at T+3+N. Hex mode: 2N write cycles.
- Mask 0, no newline: completion pulse at T+1.
- `uart_tx_write` never asserted while `uart_tx_full`=1; data stable while write held off.
- New request accepted earliest the cycle after the completion pulse.

## Structure
- Shared package: state encodings, ASCII constants (newline 0x0A, '0' 0x30, 'A' 0x41), byte/mask/address widths (8/4/9/32).
- One sub-module: `hex_nibble_to_ascii` (4-bit in, 8-bit ASCII out, combinational); remaining logic flat.

## Test plan
- Raw, mask 4'b1111, addr 0x012, word 0xDEADBEEF, FIFO never full → writes DE, AD, BE, EF at T+3..T+6, complete at T+7, `bram_rd_addr`=0x012 at T+1.
- Raw, mask 4'b0101, word 0x11223344 → writes 22 then 44 in consecutive cycles, complete at T+5.
- `ASCII_HEX`=1, `APPEND_NEWLINE`=1, mask 4'b0001, word 0x0000003A → writes 0x33, 0x41, 0x0A, then complete.
- Mask 0 → no `bram_rd_en`, no writes, complete at T+1.
- Mask 4'b1111, `uart_tx_full` held high 5 cycles after first write → no strobe while full, four bytes emitted in order exactly once; second `send_over_uart` mid-transfer ignored.
- `rst` low during SEND → outputs 0 immediately, no completion; next request after release runs normally.

Source files
------------

// File: rtl/bram_uart_sender_pkg.sv
// Shared types and constants for the BRAM-to-UART transmit sequencer.
package bram_uart_sender_pkg;

    localparam int BYTE_W = 8;
    localparam int MASK_W = 4;
    localparam int ADDR_W = 9;
    localparam int WORD_W = 32;

    localparam logic [BYTE_W-1:0] ASCII_NEWLINE = 8'h0A;
    localparam logic [BYTE_W-1:0] ASCII_ZERO    = 8'h30;
    localparam logic [BYTE_W-1:0] ASCII_A       = 8'h41;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CAPTURE,
        ST_SEND,
        ST_NEWLINE,
        ST_DONE
    } state_t;

    // Index of the highest set mask bit; bytes go out most-significant first.
    function automatic logic [1:0] top_byte(input logic [MASK_W-1:0] mask);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < MASK_W; i++) begin
            if (mask[i]) idx = i[1:0];
        end
        return idx;
    endfunction

endpackage

// File: rtl/bram_uart_sender_hex_nibble_to_ascii.sv
// Converts one 4-bit nibble to its uppercase ASCII hex character.
module hex_nibble_to_ascii
    import bram_uart_sender_pkg::*;
(
    input  logic [3:0]        nibble_i,
    output logic [BYTE_W-1:0] ascii_o
);

    assign ascii_o = (nibble_i < 4'd10) ? ASCII_ZERO + {4'b0000, nibble_i}
                                        : ASCII_A + {4'b0000, nibble_i} - 8'd10;

endmodule

// File: rtl/bram_uart_sender.sv
// Reads one BRAM word on request and streams its mask-selected bytes
// (raw or ASCII hex, optional trailing newline) into the UART TX FIFO.
module bram_uart_sender
    import bram_uart_sender_pkg::*;
#(
    parameter bit ASCII_HEX      = 1'b0,
    parameter bit APPEND_NEWLINE = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              send_over_uart,
    input  logic [MASK_W-1:0] bytes_to_read,
    input  logic [ADDR_W-1:0] bram_read_addr,
    output logic              bram_rd_en,
    output logic [ADDR_W-1:0] bram_rd_addr,
    input  logic [WORD_W-1:0] bram_rd_data,
    output logic [BYTE_W-1:0] uart_tx_data,
    output logic              uart_tx_write,
    input  logic              uart_tx_full,
    output logic              uart_send_complete,
    output logic              busy
);

    state_t              state_q;
    logic [MASK_W-1:0]   mask_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [WORD_W-1:0]   word_q;
    logic                nib_lo_q;
    logic                rd_en_q;
    logic                complete_q;

    logic [1:0]          byte_idx;
    logic [MASK_W-1:0]   byte_onehot;
    logic [MASK_W-1:0]   mask_d;
    logic [BYTE_W-1:0]   cur_byte;
    logic [3:0]          cur_nibble;
    logic [BYTE_W-1:0]   hex_char;

    assign byte_idx   = top_byte(mask_q);
    assign cur_byte   = word_q[{byte_idx, 3'b000} +: BYTE_W];
    assign cur_nibble = nib_lo_q ? cur_byte[3:0] : cur_byte[7:4];

    hex_nibble_to_ascii u_hex (
        .nibble_i (cur_nibble),
        .ascii_o  (hex_char)
    );

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        byte_onehot           = '0;
        byte_onehot[byte_idx] = 1'b1;
        mask_d                = mask_q & ~byte_onehot;
        uart_tx_data          = '0;
        uart_tx_write         = 1'b0;
        case (state_q)
            ST_SEND: begin
                uart_tx_data  = ASCII_HEX ? hex_char : cur_byte;
                uart_tx_write = ~uart_tx_full;
            end
            ST_NEWLINE: begin
                uart_tx_data  = ASCII_NEWLINE;
                uart_tx_write = ~uart_tx_full;
            end
            default: ;
        endcase
    end

    // The write strobe is gated combinationally by full so it can never assert into a full FIFO.
    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            mask_q     <= '0;
            addr_q     <= '0;
            word_q     <= '0;
            nib_lo_q   <= 1'b0;
            rd_en_q    <= 1'b0;
            complete_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    rd_en_q    <= 1'b0;
                    complete_q <= 1'b0;
                    if (send_over_uart) begin
                        mask_q   <= bytes_to_read;
                        addr_q   <= bram_read_addr;
                        nib_lo_q <= 1'b0;
                        if (bytes_to_read != '0) begin
                            state_q <= ST_FETCH;
                            rd_en_q <= 1'b1;
                        end else if (APPEND_NEWLINE) begin
                            state_q <= ST_NEWLINE;
                        end else begin
                            state_q    <= ST_DONE;
                            complete_q <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    rd_en_q <= 1'b0;
                    state_q <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    word_q  <= bram_rd_data;
                    state_q <= ST_SEND;
                end
                ST_SEND: begin
                    if (uart_tx_write) begin
                        if (ASCII_HEX && !nib_lo_q) begin
                            nib_lo_q <= 1'b1;
                        end else begin
                            nib_lo_q <= 1'b0;
                            mask_q   <= mask_d;
                            if (mask_d == '0) begin
                                if (APPEND_NEWLINE) begin
                                    state_q <= ST_NEWLINE;
                                end else begin
                                    state_q    <= ST_DONE;
                                    complete_q <= 1'b1;
                                end
                            end
                        end
                    end
                end
                ST_NEWLINE: begin
                    if (uart_tx_write) begin
                        state_q    <= ST_DONE;
                        complete_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    complete_q <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bram_rd_en         = rd_en_q;
    assign bram_rd_addr       = addr_q;
    assign uart_send_complete = complete_q;
    assign busy               = (state_q != ST_IDLE);

endmodule
